stopwatch_bcd: RTL and testbench

//   MM:SS stopwatch driven by the slow divided clock from the clock divider.
//   - tick_in is sampled as a data signal in the clock_in domain, never used as a clock.
//   - Start/stop and clear pulses come from debounced buttons.
//   - BCD digit outputs feed the 7-segment display mux.

---
 rtl/stopwatch_bcd.sv | 163 ++++++++++++++++
 tb/tb_stopwatch_bcd.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_bcd.sv
// MM:SS BCD stopwatch advanced by rising edges of a divided tick level sampled in the clock_in domain.
// Optional lap display hold is compiled in with `define LAP_HOLD_EN (default build: hold absent).
module stopwatch_bcd #(
    parameter int TICKS_PER_SEC = 1,
    parameter int WRAP_MINUTES  = 60
) (
    input  logic       clock_in,
    input  logic       reset,
    input  logic       tick_in,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       lap,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       running,
    output logic       rollover,
    output logic       lap_active
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    localparam logic [7:0] PRESC_MAX = 8'(TICKS_PER_SEC - 1);
    localparam logic [3:0] WRAP_TENS = 4'((WRAP_MINUTES - 1) / 10);
    localparam logic [3:0] WRAP_ONES = 4'((WRAP_MINUTES - 1) % 10);

    state_t     state_q;
    logic       tick_q, running_q, rollover_q;
    logic [7:0] presc_q, presc_d;
    logic [3:0] sec_ones_q, sec_tens_q, min_ones_q, min_tens_q;
    logic [3:0] sec_ones_d, sec_tens_d, min_ones_d, min_tens_d;
    logic       rise, advance, wrap_d;

    assign rise    = tick_in & ~tick_q;
    assign advance = (state_q == RUN) && rise && (presc_q == PRESC_MAX);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        presc_d    = presc_q;
        sec_ones_d = sec_ones_q;
        sec_tens_d = sec_tens_q;
        min_ones_d = min_ones_q;
        min_tens_d = min_tens_q;
        wrap_d     = 1'b0;
        if (state_q == RUN && rise) begin
            presc_d = (presc_q == PRESC_MAX) ? 8'd0 : presc_q + 8'd1;
        end
        if (advance) begin
            if (sec_ones_q != 4'd9) begin
                sec_ones_d = sec_ones_q + 4'd1;
            end else begin
                sec_ones_d = 4'd0;
                if (sec_tens_q != 4'd5) begin
                    sec_tens_d = sec_tens_q + 4'd1;
                end else begin
                    sec_tens_d = 4'd0;
                    // Minutes wrap at the configured modulus rather than at 99.
                    if (min_tens_q == WRAP_TENS && min_ones_q == WRAP_ONES) begin
                        min_ones_d = 4'd0;
                        min_tens_d = 4'd0;
                        wrap_d     = 1'b1;
                    end else if (min_ones_q == 4'd9) begin
                        min_ones_d = 4'd0;
                        min_tens_d = min_tens_q + 4'd1;
                    end else begin
                        min_ones_d = min_ones_q + 4'd1;
                    end
                end
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            state_q    <= IDLE;
            tick_q     <= 1'b0;
            presc_q    <= 8'd0;
            sec_ones_q <= 4'd0;
            sec_tens_q <= 4'd0;
            min_ones_q <= 4'd0;
            min_tens_q <= 4'd0;
            running_q  <= 1'b0;
            rollover_q <= 1'b0;
        end else begin
            tick_q <= tick_in;
            if (clear) begin
                state_q    <= IDLE;
                presc_q    <= 8'd0;
                sec_ones_q <= 4'd0;
                sec_tens_q <= 4'd0;
                min_ones_q <= 4'd0;
                min_tens_q <= 4'd0;
                running_q  <= 1'b0;
                rollover_q <= 1'b0;
            end else begin
                presc_q    <= presc_d;
                sec_ones_q <= sec_ones_d;
                sec_tens_q <= sec_tens_d;
                min_ones_q <= min_ones_d;
                min_tens_q <= min_tens_d;
                rollover_q <= wrap_d;
                if (start_stop) begin
                    case (state_q)
                        RUN: begin
                            state_q   <= PAUSE;
                            running_q <= 1'b0;
                        end
                        default: begin
                            state_q   <= RUN;
                            running_q <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end

    assign running  = running_q;
    assign rollover = rollover_q;

`ifdef LAP_HOLD_EN
    logic       hold_q;
    logic [3:0] snap_so_q, snap_st_q, snap_mo_q, snap_mt_q;
    logic       lap_ok;

    assign lap_ok = lap && !clear && (state_q != IDLE);

    always_ff @(posedge clock_in) begin
        if (reset || clear) begin
            hold_q <= 1'b0;
        end else if (lap_ok) begin
            hold_q <= ~hold_q;
        end
    end

    // NOTE: the snapshot is not reset; it is only ever shown after being loaded while hold_q is set.
    always_ff @(posedge clock_in) begin
        if (!reset && lap_ok && !hold_q) begin
            snap_so_q <= sec_ones_q;
            snap_st_q <= sec_tens_q;
            snap_mo_q <= min_ones_q;
            snap_mt_q <= min_tens_q;
        end
    end

    assign sec_ones   = hold_q ? snap_so_q : sec_ones_q;
    assign sec_tens   = hold_q ? snap_st_q : sec_tens_q;
    assign min_ones   = hold_q ? snap_mo_q : min_ones_q;
    assign min_tens   = hold_q ? snap_mt_q : min_tens_q;
    assign lap_active = hold_q;
`else
    logic unused_lap;

    assign unused_lap = lap;
    assign sec_ones   = sec_ones_q;
    assign sec_tens   = sec_tens_q;
    assign min_ones   = min_ones_q;
    assign min_tens   = min_tens_q;
    assign lap_active = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Bench for stopwatch_bcd: three parameterisations driven in parallel, directed
// scenarios against hand-derived values plus a random run against a seconds-count model.
module tb_stopwatch_bcd;
    logic clock_in = 1'b0;
    logic reset = 1'b1, tick_in = 1'b0, start_stop = 1'b0, clear = 1'b0, lap = 1'b0;
    always #5 clock_in = ~clock_in;

    logic [2:0][3:0] so, st, mo, mt;
    logic [2:0]      run_o, roll_o, lapa_o;

    stopwatch_bcd #(.TICKS_PER_SEC(1), .WRAP_MINUTES(60)) u_dut (
        .clock_in(clock_in), .reset(reset), .tick_in(tick_in), .start_stop(start_stop),
        .clear(clear), .lap(lap), .sec_ones(so[0]), .sec_tens(st[0]), .min_ones(mo[0]),
        .min_tens(mt[0]), .running(run_o[0]), .rollover(roll_o[0]), .lap_active(lapa_o[0]));
    stopwatch_bcd #(.TICKS_PER_SEC(1), .WRAP_MINUTES(1)) u_wrap (
        .clock_in(clock_in), .reset(reset), .tick_in(tick_in), .start_stop(start_stop),
        .clear(clear), .lap(lap), .sec_ones(so[1]), .sec_tens(st[1]), .min_ones(mo[1]),
        .min_tens(mt[1]), .running(run_o[1]), .rollover(roll_o[1]), .lap_active(lapa_o[1]));
    stopwatch_bcd #(.TICKS_PER_SEC(4), .WRAP_MINUTES(2)) u_pre (
        .clock_in(clock_in), .reset(reset), .tick_in(tick_in), .start_stop(start_stop),
        .clear(clear), .lap(lap), .sec_ones(so[2]), .sec_tens(st[2]), .min_ones(mo[2]),
        .min_tens(mt[2]), .running(run_o[2]), .rollover(roll_o[2]), .lap_active(lapa_o[2]));

    // Model keeps elapsed time as a plain seconds count; st: 0 idle, 1 run, 2 pause.
    typedef struct {
        int st;
        int presc;
        int secs;
        bit roll;
        bit hold;
        int snap;
    } mdl_t;

    mdl_t m[3];
    int   tps_c[3]  = '{1, 1, 4};
    int   wrap_c[3] = '{60, 1, 2};
    bit   prev_tick;
    int   total = 0;
    int   bad = 0;

    function automatic mdl_t mstep(mdl_t c, int tps, int wrap, bit rise, bit ss, bit clr, bit lp);
        mdl_t n = c;
        n.roll = 1'b0;
        if (clr) begin
            n = '{default: 0};
            return n;
        end
        if (c.st == 1 && rise) begin
            if (c.presc == tps - 1) begin
                n.presc = 0;
                n.secs  = (c.secs + 1) % (wrap * 60);
                n.roll  = (n.secs == 0);
            end else begin
                n.presc = c.presc + 1;
            end
        end
        if (ss) n.st = (c.st == 1) ? 2 : 1;
`ifdef LAP_HOLD_EN
        if (lp && c.st != 0) begin
            n.hold = !c.hold;
            if (!c.hold) n.snap = c.secs;
        end
`else
        if (lp) n.hold = 1'b0;
`endif
        return n;
    endfunction

    function automatic logic [18:0] vec(int mins, int secs, bit r, bit ro, bit la);
        return {4'(mins / 10), 4'(mins % 10), 4'(secs / 10), 4'(secs % 10), r, ro, la};
    endfunction

    function automatic logic [18:0] mvec(mdl_t c);
        int shown = c.hold ? c.snap : c.secs;
        return vec(shown / 60, shown % 60, c.st == 1, c.roll, c.hold);
    endfunction

    function automatic logic [18:0] got(int i);
        return {mt[i], mo[i], st[i], so[i], run_o[i], roll_o[i], lapa_o[i]};
    endfunction

    task automatic step(input bit t, input bit ss, input bit clr, input bit lp);
        bit rise;
        tick_in = t; start_stop = ss; clear = clr; lap = lp;
        @(posedge clock_in);
        rise = t & ~prev_tick;
        for (int i = 0; i < 3; i++) begin
            if (reset) m[i] = '{default: 0};
            else m[i] = mstep(m[i], tps_c[i], wrap_c[i], rise, ss, clr, lp);
        end
        prev_tick = reset ? 1'b0 : t;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
    endtask

    task automatic rises(input int n);
        repeat (n) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            total++;
            if (got(i) !== vec(0, 0, 0, 0, 0)) begin
                bad++; $display("FAIL reset_state dut%0d got=%h exp=%h", i, got(i), vec(0, 0, 0, 0, 0));
            end
        end
    endtask

    task automatic test_count();
        bit seen_roll = 1'b0;
        do_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (5) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            seen_roll |= roll_o[0];
            step(1'b0, 1'b0, 1'b0, 1'b0);
            seen_roll |= roll_o[0];
        end
        total++;
        if (got(0) !== vec(0, 5, 1, 0, 0)) begin
            bad++; $display("FAIL t1_count got=%h exp=%h", got(0), vec(0, 5, 1, 0, 0));
        end
        total++;
        if (seen_roll !== 1'b0) begin
            bad++; $display("FAIL t1_no_rollover got=%0b exp=0", seen_roll);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        rises(59);
        total++;
        if (got(1) !== vec(0, 59, 1, 0, 0)) begin
            bad++; $display("FAIL t2_at_59 got=%h exp=%h", got(1), vec(0, 59, 1, 0, 0));
        end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        total++;
        if (got(1) !== vec(0, 0, 1, 1, 0)) begin
            bad++; $display("FAIL t2_wrap got=%h exp=%h", got(1), vec(0, 0, 1, 1, 0));
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        total++;
        if (got(1) !== vec(0, 0, 1, 0, 0)) begin
            bad++; $display("FAIL t2_roll_one_cycle got=%h exp=%h", got(1), vec(0, 0, 1, 0, 0));
        end
    endtask

    task automatic test_pause();
        do_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        rises(3);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        rises(4);
        total++;
        if (got(0) !== vec(0, 3, 0, 0, 0)) begin
            bad++; $display("FAIL t3_paused got=%h exp=%h", got(0), vec(0, 3, 0, 0, 0));
        end
        step(1'b0, 1'b1, 1'b0, 1'b0);
        rises(2);
        total++;
        if (got(0) !== vec(0, 5, 1, 0, 0)) begin
            bad++; $display("FAIL t3_resumed got=%h exp=%h", got(0), vec(0, 5, 1, 0, 0));
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        rises(2);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        total++;
        if (got(0) !== vec(0, 3, 0, 0, 0)) begin
            bad++; $display("FAIL run_rise_and_stop got=%h exp=%h", got(0), vec(0, 3, 0, 0, 0));
        end
    endtask

    task automatic test_clear();
        do_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        rises(7);
        total++;
        if (got(0) !== vec(0, 7, 1, 0, 0)) begin
            bad++; $display("FAIL t4_at_07 got=%h exp=%h", got(0), vec(0, 7, 1, 0, 0));
        end
        step(1'b0, 1'b1, 1'b1, 1'b0);
        total++;
        if (got(0) !== vec(0, 0, 0, 0, 0)) begin
            bad++; $display("FAIL t4_clear_wins got=%h exp=%h", got(0), vec(0, 0, 0, 0, 0));
        end
        step(1'b1, 1'b1, 1'b0, 1'b0);
        total++;
        if (got(0) !== vec(0, 0, 1, 0, 0)) begin
            bad++; $display("FAIL t4_start_no_advance got=%h exp=%h", got(0), vec(0, 0, 1, 0, 0));
        end
    endtask

    task automatic test_prescaler();
        do_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        rises(7);
        total++;
        if (got(2) !== vec(0, 1, 1, 0, 0)) begin
            bad++; $display("FAIL t5_seven_rises got=%h exp=%h", got(2), vec(0, 1, 1, 0, 0));
        end
        step(1'b0, 1'b1, 1'b0, 1'b0);
        rises(3);
        total++;
        if (got(2) !== vec(0, 1, 0, 0, 0)) begin
            bad++; $display("FAIL t5_paused got=%h exp=%h", got(2), vec(0, 1, 0, 0, 0));
        end
        step(1'b0, 1'b1, 1'b0, 1'b0);
        rises(1);
        total++;
        if (got(2) !== vec(0, 2, 1, 0, 0)) begin
            bad++; $display("FAIL t5_presc_held got=%h exp=%h", got(2), vec(0, 2, 1, 0, 0));
        end
    endtask

`ifdef LAP_HOLD_EN
    task automatic test_lap();
        do_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        rises(10);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        rises(5);
        total++;
        if (got(0) !== vec(0, 10, 1, 0, 1)) begin
            bad++; $display("FAIL t6_held got=%h exp=%h", got(0), vec(0, 10, 1, 0, 1));
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        total++;
        if (got(0) !== vec(0, 15, 1, 0, 0)) begin
            bad++; $display("FAIL t6_release got=%h exp=%h", got(0), vec(0, 15, 1, 0, 0));
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        total++;
        if (got(0) !== vec(0, 0, 0, 0, 0)) begin
            bad++; $display("FAIL t6_clear_release got=%h exp=%h", got(0), vec(0, 0, 0, 0, 0));
        end
    endtask
`else
    task automatic test_lap();
        do_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        rises(2);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        rises(1);
        total++;
        if (got(0) !== vec(0, 3, 1, 0, 0)) begin
            bad++; $display("FAIL lap_ignored got=%h exp=%h", got(0), vec(0, 3, 1, 0, 0));
        end
    endtask
`endif

    task automatic test_random();
        bit t, ss, clr, lp;
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            t   = 1'($urandom_range(0, 1));
            ss  = ($urandom_range(0, 11) == 0);
            clr = ($urandom_range(0, 799) == 0);
            lp  = ($urandom_range(0, 15) == 0);
            step(t, ss, clr, lp);
            for (int i = 0; i < 3; i++) begin
                total++;
                if (got(i) !== mvec(m[i])) begin
                    bad++;
                    $display("FAIL random dut%0d cycle=%0d got=%h exp=%h", i, n, got(i), mvec(m[i]));
                end
            end
        end
    endtask

    initial begin
        prev_tick = 1'b0;
        for (int i = 0; i < 3; i++) m[i] = '{default: 0};
        test_reset();
        test_count();
        test_wrap();
        test_pause();
        test_back_to_back();
        test_clear();
        test_prescaler();
        test_lap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
